fetch_unit: RTL and testbench

Dual-issue instruction fetch stage sitting directly upstream of the instruction ROM and downstream of nothing but the redirect path. Owns the program counter and drives the ROM word address. Pairs the ROM's registered two-instruction output with the matching PCs and presents a valid-tagged fetch packet to decode. Handles decode stalls, branch/jump redirects, an end-of-ROM slot-2 kill, and a sticky halt on misaligned redirect targets.

---
 rtl/fetch_unit_pkg.sv | 16 +
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the dual-issue fetch stage.
package fetch_unit_pkg;

    // RISC-V canonical NOP (addi x0, x0, 0)
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Two 4-byte instructions are fetched per packet
    localparam logic [31:0] PC_STEP = 32'd8;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Dual-issue fetch: owns the PC, addresses the ROM and pairs its registered
// two-word output with the PCs the data belongs to.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ROM_AW   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_instr1,
    input  logic [31:0]       rom_instr2,
    output logic              if_valid,
    output logic              if_valid2,
    output logic [31:0]       if_pc1,
    output logic [31:0]       if_pc2,
    output logic [31:0]       if_instr1,
    output logic [31:0]       if_instr2,
    output logic              halted,
    output logic [31:0]       fetch_cnt
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_f_q, pc_f_d;   // address being read from the ROM this cycle
    logic [31:0]  pc_d_q, pc_d_d;   // address whose data is on rom_instr*
    logic [31:0]  fetch_cnt_q, fetch_cnt_d;
    logic         redir_bad;
    logic         accept;

    assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign accept    = if_valid && !stall && !redirect_valid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= BOOT;
        else        state_q <= state_d;
    end

    // Next-state: BOOT lasts one cycle, a misaligned redirect halts for good
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (redir_bad) state_d = HALT;
            HALT:    state_d = HALT;
            default: state_d = BOOT;
        endcase
    end

    // Outputs: packet valid only in RUN and not squashed by a redirect;
    // ROM address chosen so that a stall re-reads the word already shown
    always_comb begin
        if_valid = 1'b0;
        rom_addr = pc_d_q[ROM_AW+1:2];
        case (state_q)
            BOOT: rom_addr = pc_f_q[ROM_AW+1:2];
            RUN: begin
                if_valid = !redirect_valid;
                if (redirect_valid) rom_addr = redirect_pc[ROM_AW+1:2];
                else if (stall)     rom_addr = pc_d_q[ROM_AW+1:2];
                else                rom_addr = pc_f_q[ROM_AW+1:2];
            end
            default: rom_addr = pc_d_q[ROM_AW+1:2];
        endcase
    end

    // ROM's addr+1 wraps to word 0 at the top, so slot 2 is dropped there
    assign if_valid2 = if_valid && (pc_d_q[ROM_AW+1:2] != {ROM_AW{1'b1}});
    assign if_pc1    = pc_d_q;
    assign if_pc2    = pc_d_q + 32'd4;
    assign if_instr1 = rom_instr1;
    assign if_instr2 = rom_instr2;
    assign halted    = (state_q == HALT);
    assign fetch_cnt = fetch_cnt_q;

    // Next PC pair and packet counter
    always_comb begin
        pc_f_d      = pc_f_q;
        pc_d_d      = pc_d_q;
        fetch_cnt_d = fetch_cnt_q + {31'd0, accept};
        case (state_q)
            BOOT: begin
                pc_d_d = pc_f_q;
                pc_f_d = pc_f_q + PC_STEP;
            end
            RUN: begin
                if (redirect_valid) begin
                    // Misaligned target: freeze PCs, FSM moves to HALT
                    if (!redir_bad) begin
                        pc_d_d = redirect_pc;
                        pc_f_d = redirect_pc + PC_STEP;
                    end
                end else if (!stall) begin
                    pc_d_d = pc_f_q;
                    pc_f_d = pc_f_q + PC_STEP;
                end
            end
            default: ;
        endcase
    end

    // PC and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_f_q      <= RESET_PC;
            pc_d_q      <= RESET_PC;
            fetch_cnt_q <= 32'd0;
        end else begin
            pc_f_q      <= pc_f_d;
            pc_d_q      <= pc_d_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a registered dual-read ROM model.
module tb_fetch_unit;

    localparam int ROM_AW = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              stall;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic [ROM_AW-1:0] rom_addr;
    logic [31:0]       rom_instr1, rom_instr2;
    logic              if_valid, if_valid2, halted;
    logic [31:0]       if_pc1, if_pc2, if_instr1, if_instr2, fetch_cnt;

    logic [31:0] mem [0:(1<<ROM_AW)-1];
    logic [ROM_AW-1:0] addr_p1;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0), .ROM_AW(ROM_AW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .rom_addr(rom_addr), .rom_instr1(rom_instr1), .rom_instr2(rom_instr2),
        .if_valid(if_valid), .if_valid2(if_valid2),
        .if_pc1(if_pc1), .if_pc2(if_pc2),
        .if_instr1(if_instr1), .if_instr2(if_instr2),
        .halted(halted), .fetch_cnt(fetch_cnt)
    );

    // Registered ROM, second port reads the next word with wrap
    assign addr_p1 = rom_addr + 1'b1;
    always_ff @(posedge clk) begin
        rom_instr1 <= mem[rom_addr];
        rom_instr2 <= mem[addr_p1];
    end

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        logic [ROM_AW-1:0] idx;
        idx = pc[ROM_AW+1:2];
        return mem[idx];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        v1;
        logic        v2;
        logic        hlt;
        logic [31:0] pc1;
        logic [31:0] cnt;
        logic [9:0]  addr;
    } vec_t;

    vec_t tbl [14];

    initial begin
        for (int i = 0; i < (1 << ROM_AW); i++) mem[i] = 32'h0A00_0000 + i;
        mem[0] = 32'h0010_0293;
        mem[1] = 32'h0020_0313;

        //        stall rv  rpc          v1 v2 hlt pc1           cnt addr
        tbl[0]  = '{0, 0, 32'h0,         1, 1, 0, 32'h0000,    0, 10'd2};
        tbl[1]  = '{0, 0, 32'h0,         1, 1, 0, 32'h0008,    1, 10'd4};
        tbl[2]  = '{1, 0, 32'h0,         1, 1, 0, 32'h0010,    2, 10'd4};
        tbl[3]  = '{1, 0, 32'h0,         1, 1, 0, 32'h0010,    2, 10'd4};
        tbl[4]  = '{1, 0, 32'h0,         1, 1, 0, 32'h0010,    2, 10'd4};
        tbl[5]  = '{0, 0, 32'h0,         1, 1, 0, 32'h0010,    2, 10'd6};
        tbl[6]  = '{1, 1, 32'h20,        0, 0, 0, 32'h0018,    3, 10'd8};
        tbl[7]  = '{0, 0, 32'h0,         1, 1, 0, 32'h0020,    3, 10'd10};
        tbl[8]  = '{0, 1, 32'hFFC,       0, 0, 0, 32'h0028,    4, 10'd1023};
        tbl[9]  = '{0, 0, 32'h0,         1, 0, 0, 32'h0FFC,    4, 10'd1};
        tbl[10] = '{0, 0, 32'h0,         1, 1, 0, 32'h1004,    5, 10'd3};
        tbl[11] = '{0, 1, 32'h22,        0, 0, 0, 32'h100C,    6, 10'd8};
        tbl[12] = '{0, 0, 32'h0,         0, 0, 1, 32'h100C,    6, 10'd3};
        tbl[13] = '{0, 1, 32'h40,        0, 0, 1, 32'h100C,    6, 10'd3};

        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid",  {31'd0, if_valid},  32'd0);
        chk("rst_valid2", {31'd0, if_valid2}, 32'd0);
        chk("rst_pc1",    if_pc1,    32'h0);
        chk("rst_pc2",    if_pc2,    32'h4);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_cnt",    fetch_cnt, 32'd0);
        chk("rst_addr",   {22'd0, rom_addr}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            stall = tbl[i].stall; redirect_valid = tbl[i].rv; redirect_pc = tbl[i].rpc;
            @(negedge clk);
            chk($sformatf("r%0d_valid", i),  {31'd0, if_valid},  {31'd0, tbl[i].v1});
            chk($sformatf("r%0d_valid2", i), {31'd0, if_valid2}, {31'd0, tbl[i].v2});
            chk($sformatf("r%0d_halted", i), {31'd0, halted},    {31'd0, tbl[i].hlt});
            chk($sformatf("r%0d_pc1", i),    if_pc1,    tbl[i].pc1);
            chk($sformatf("r%0d_pc2", i),    if_pc2,    tbl[i].pc1 + 32'd4);
            chk($sformatf("r%0d_cnt", i),    fetch_cnt, tbl[i].cnt);
            chk($sformatf("r%0d_addr", i),   {22'd0, rom_addr}, {22'd0, tbl[i].addr});
            if (tbl[i].v1) begin
                chk($sformatf("r%0d_instr1", i), if_instr1, word_at(tbl[i].pc1));
                chk($sformatf("r%0d_instr2", i), if_instr2, word_at(tbl[i].pc1 + 32'd4));
            end
        end

        // Spot checks against the literal program image
        chk("img_word0", mem[0], 32'h0010_0293);

        // Reset out of HALT, asserted mid-cycle
        @(posedge clk); #1;
        redirect_valid = 1'b0; stall = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("hrst_halted", {31'd0, halted},   32'd0);
        chk("hrst_cnt",    fetch_cnt,         32'd0);
        chk("hrst_valid",  {31'd0, if_valid}, 32'd0);
        chk("hrst_pc1",    if_pc1,            32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Run freely to pc 0x40 (9th packet), then reset asynchronously
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (k == 1) begin
                chk("run_pc1_first", if_pc1,    32'h0);
                chk("run_i1_first",  if_instr1, 32'h0010_0293);
                chk("run_i2_first",  if_instr2, 32'h0020_0313);
            end
        end
        chk("run_pc1_40", if_pc1,    32'h40);
        chk("run_cnt_40", fetch_cnt, 32'd8);
        chk("run_v_40",   {31'd0, if_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, if_valid}, 32'd0);
        chk("arst_pc1",   if_pc1,    32'h0);
        chk("arst_cnt",   fetch_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rel_valid",  {31'd0, if_valid}, 32'd1);
        chk("rel_pc1",    if_pc1,    32'h0);
        chk("rel_instr1", if_instr1, 32'h0010_0293);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rel_pc1_2",  if_pc1,    32'h8);
        chk("rel_cnt_2",  fetch_cnt, 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
